// File: rtl/fetch_unit_if.sv
// Fetch unit boundary: instruction memory request/response channel,
// decode-facing instruction handshake and execute redirect.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output ins_valid, ins, ins_pc, fetch_misaligned,
    input  ins_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  ins_valid, ins, ins_pc, fetch_misaligned,
    output ins_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps a prefetch FIFO in front of
// decode and discards in-flight words after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [7:0]    drop_q, drop_d;
  logic [AW-1:0] frd_q, frd_d;
  logic [AW-1:0] fwr_q, fwr_d;
  logic [AW-1:0] qrd_q, qrd_d;
  logic [AW-1:0] qwr_q, qwr_d;
  logic [31:0]   last_pc_q, last_pc_d;

  logic [31:0]   fdat_q [DEPTH];
  logic [31:0]   fpc_q  [DEPTH];
  logic [31:0]   qpc_q  [DEPTH];

  logic          valid;
  logic          aligned;
  logic          req_ok;
  logic          hs;
  logic          push;
  logic          pop;
  logic [8:0]    owed;

  always_comb begin
    valid   = (cnt_q != '0);
    aligned = (bus.redirect_pc[1:0] == 2'b00);
    req_ok  = (state_q == RUN) && !bus.redirect
           && (({1'b0, cnt_q} + {1'b0, infl_q}) < LIM);
    hs      = req_ok && bus.imem_req_ready;
    pop     = valid && bus.ins_ready;
    push    = bus.imem_resp_valid && !bus.redirect
           && (drop_q == '0) && (infl_q != '0);
    owed    = {1'b0, drop_q} + 9'(infl_q) + 9'(hs);

    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    infl_d    = infl_q;
    drop_d    = drop_q;
    frd_d     = frd_q;
    fwr_d     = fwr_q;
    qrd_d     = qrd_q;
    qwr_d     = qwr_q;
    last_pc_d = valid ? fpc_q[frd_q] : last_pc_q;

    if (bus.redirect) begin
      cnt_d  = '0;
      infl_d = '0;
      frd_d  = '0;
      fwr_d  = '0;
      qrd_d  = '0;
      qwr_d  = '0;
      // a response landing now belongs to the old stream
      if (bus.imem_resp_valid && (owed != '0))
        drop_d = 8'(owed - 9'd1);
      else
        drop_d = owed[7:0];
      if (aligned) begin
        state_d = RUN;
        pc_d    = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        state_d = FAULT;
      end
    end else begin
      if (state_q == IDLE)
        state_d = RUN;
      if (hs) begin
        pc_d  = pc_q + 32'd4;
        qwr_d = qwr_q + 1'b1;
      end
      if (push) begin
        qrd_d = qrd_q + 1'b1;
        fwr_d = fwr_q + 1'b1;
      end
      if (pop)
        frd_d = frd_q + 1'b1;
      if (bus.imem_resp_valid && (drop_q != '0))
        drop_d = drop_q - 8'd1;
      infl_d = infl_q + CW'(hs) - CW'(push);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
      infl_q    <= '0;
      drop_q    <= '0;
      frd_q     <= '0;
      fwr_q     <= '0;
      qrd_q     <= '0;
      qwr_q     <= '0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      infl_q    <= infl_d;
      drop_q    <= drop_d;
      frd_q     <= frd_d;
      fwr_q     <= fwr_d;
      qrd_q     <= qrd_d;
      qwr_q     <= qwr_d;
      last_pc_q <= last_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs)
      qpc_q[qwr_q] <= pc_q;
    if (push) begin
      fdat_q[fwr_q] <= bus.imem_resp_data;
      fpc_q[fwr_q]  <= qpc_q[qrd_q];
    end
  end

  assign bus.imem_req_valid   = req_ok;
  assign bus.imem_req_addr    = pc_q;
  assign bus.ins_valid        = valid;
  assign bus.ins              = valid ? fdat_q[frd_q] : NOP;
  assign bus.ins_pc           = valid ? fpc_q[frd_q] : last_pc_q;
  assign bus.fetch_misaligned = (state_q == FAULT);
endmodule
